// File: rtl/conv_frame_streamer_if.sv
// rtl/conv_frame_streamer_if.sv - host and engine signal bundle for conv_frame_streamer
interface conv_frame_streamer_if #(
  parameter int bitWidth   = 16,
  parameter int imgDim     = 8,
  parameter int outputSize = 16
);
  localparam int numPixels = imgDim * imgDim;
  localparam int addrW     = $clog2(numPixels);

  logic                                wrEn;
  logic [addrW-1:0]                    wrAddr;
  logic signed [bitWidth-1:0]          wrData;
  logic                                start;
  logic                                busy;
  logic                                convReset;
  logic signed [bitWidth-1:0]          inputPixel;
  logic                                pixelValid;
  logic                                outputValid;
  logic [outputSize-1:0][bitWidth-1:0] resultIn;
  logic [outputSize-1:0][bitWidth-1:0] result;
  logic                                resultValid;
  logic                                timeout;

  modport slave (
    input  wrEn, wrAddr, wrData, start, outputValid, resultIn,
    output busy, convReset, inputPixel, pixelValid, result, resultValid, timeout
  );

  modport master (
    output wrEn, wrAddr, wrData, start, outputValid, resultIn,
    input  busy, convReset, inputPixel, pixelValid, result, resultValid, timeout
  );
endinterface

// File: rtl/conv_frame_streamer.sv
// rtl/conv_frame_streamer.sv - frame buffer and pixel streamer feeding the conv2d engine
module conv_frame_streamer #(
  parameter int bitWidth      = 16,
  parameter int imgDim        = 8,
  parameter int outputSize    = 16,
  parameter int timeoutCycles = 1023
) (
  input logic                  i_clk_p,
  input logic                  i_reset,
  conv_frame_streamer_if.slave io_bus
);
  localparam int numPixels = imgDim * imgDim;
  localparam int addrW     = $clog2(numPixels);
  localparam int waitW     = $clog2(timeoutCycles + 1);
  localparam logic [addrW-1:0] lastPix  = addrW'(numPixels - 1);
  localparam logic [waitW-1:0] lastWait = waitW'(timeoutCycles - 1);

  typedef enum logic [1:0] {IDLE, PRIME, STREAM, WAIT} state_t;

  state_t r_state, w_state_nxt;

  logic signed [bitWidth-1:0]          r_buf [numPixels];
  logic [addrW-1:0]                    r_pix_cnt, w_pix_cnt_nxt;
  logic [waitW-1:0]                    r_wait_cnt, w_wait_cnt_nxt;
  logic                                r_busy, w_busy_nxt;
  logic                                r_conv_rst, w_conv_rst_nxt;
  logic signed [bitWidth-1:0]          r_pixel, w_pixel_nxt;
  logic                                r_pvalid, w_pvalid_nxt;
  logic [outputSize-1:0][bitWidth-1:0] r_result, w_result_nxt;
  logic                                r_rvalid, w_rvalid_nxt;
  logic                                r_timeout, w_timeout_nxt;

  // Buffer has no reset so a frame survives an aborted transfer.
  always_ff @(posedge i_clk_p) begin
    if (r_state == IDLE && io_bus.wrEn)
      r_buf[io_bus.wrAddr] <= io_bus.wrData;
  end

  always_ff @(posedge i_clk_p) begin
    if (i_reset) begin
      r_state    <= IDLE;
      r_pix_cnt  <= '0;
      r_wait_cnt <= '0;
      r_busy     <= 1'b0;
      r_conv_rst <= 1'b0;
      r_pixel    <= '0;
      r_pvalid   <= 1'b0;
      r_result   <= '0;
      r_rvalid   <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_pix_cnt  <= w_pix_cnt_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
      r_busy     <= w_busy_nxt;
      r_conv_rst <= w_conv_rst_nxt;
      r_pixel    <= w_pixel_nxt;
      r_pvalid   <= w_pvalid_nxt;
      r_result   <= w_result_nxt;
      r_rvalid   <= w_rvalid_nxt;
      r_timeout  <= w_timeout_nxt;
    end
  end

  // Next-state logic also computes next output values, so every output leaves a flop.
  always_comb begin
    w_state_nxt    = r_state;
    w_pix_cnt_nxt  = r_pix_cnt;
    w_wait_cnt_nxt = r_wait_cnt;
    w_conv_rst_nxt = 1'b0;
    w_pixel_nxt    = '0;
    w_pvalid_nxt   = 1'b0;
    w_result_nxt   = r_result;
    w_rvalid_nxt   = 1'b0;
    w_timeout_nxt  = r_timeout;
    unique case (r_state)
      IDLE: begin
        if (io_bus.start) begin
          w_state_nxt    = PRIME;
          w_timeout_nxt  = 1'b0;
          w_conv_rst_nxt = 1'b1;
        end
      end
      PRIME: begin
        w_state_nxt   = STREAM;
        w_pix_cnt_nxt = '0;
        w_pixel_nxt   = r_buf[0];
        w_pvalid_nxt  = 1'b1;
      end
      STREAM: begin
        if (r_pix_cnt == lastPix) begin
          w_state_nxt    = WAIT;
          w_wait_cnt_nxt = '0;
        end else begin
          w_pix_cnt_nxt = r_pix_cnt + 1'b1;
          w_pixel_nxt   = r_buf[w_pix_cnt_nxt];
          w_pvalid_nxt  = 1'b1;
        end
      end
      WAIT: begin
        w_wait_cnt_nxt = r_wait_cnt + 1'b1;
        if (io_bus.outputValid) begin
          w_state_nxt  = IDLE;
          w_result_nxt = io_bus.resultIn;
          w_rvalid_nxt = 1'b1;
        end else if (r_wait_cnt == lastWait) begin
          w_state_nxt   = IDLE;
          w_timeout_nxt = 1'b1;
        end
      end
    endcase
    w_busy_nxt = (w_state_nxt != IDLE);
  end

  assign io_bus.busy        = r_busy;
  assign io_bus.convReset   = r_conv_rst;
  assign io_bus.inputPixel  = r_pixel;
  assign io_bus.pixelValid  = r_pvalid;
  assign io_bus.result      = r_result;
  assign io_bus.resultValid = r_rvalid;
  assign io_bus.timeout     = r_timeout;
endmodule

// File: tb/tb_conv_frame_streamer.sv
// tb/tb_conv_frame_streamer.sv - randomized self-checking bench for conv_frame_streamer
module tb_conv_frame_streamer;
  localparam int BW   = 16;
  localparam int DIM  = 8;
  localparam int OSZ  = 16;
  localparam int TMO  = 1023;
  localparam int NPIX = DIM * DIM;
  localparam int RW   = OSZ * BW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  conv_frame_streamer_if #(.bitWidth(BW), .imgDim(DIM), .outputSize(OSZ)) bus();

  conv_frame_streamer #(.bitWidth(BW), .imgDim(DIM), .outputSize(OSZ), .timeoutCycles(TMO)) dut (
    .i_clk_p (clk),
    .i_reset (rst),
    .io_bus  (bus.slave)
  );

  int n_cmp = 0;
  int n_err = 0;

  logic [BW-1:0] m_buf [NPIX];
  logic [RW-1:0] m_result;
  logic          m_timeout;

  task automatic chk(input string tag, input logic [RW-1:0] got, input logic [RW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [RW-1:0] rand_vec();
    logic [RW-1:0] v;
    for (int i = 0; i < RW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic write_buf(input int a, input logic [BW-1:0] d);
    bus.wrEn   = 1'b1;
    bus.wrAddr = 6'(a);
    bus.wrData = d;
    tick();
    bus.wrEn   = 1'b0;
    m_buf[a]   = d;
  endtask

  // ov_n: WAIT cycle (1-based) at which the stub engine raises outputValid; 0 = never.
  task automatic run_frame(input int ov_n, input bit disturb, input bit stale_ov,
                           input logic [RW-1:0] res, input bit chain_start);
    int end_edge;
    logic [BW-1:0] got_q[$];
    int conv_n, conv_edge, rv_n, first_pv, last_pv;
    bit busy_ok;
    end_edge  = (ov_n > 0) ? (NPIX + 1 + ov_n) : (NPIX + 1 + TMO);
    conv_n    = 0;
    conv_edge = -1;
    rv_n      = 0;
    first_pv  = -1;
    last_pv   = -1;
    busy_ok   = 1'b1;
    bus.resultIn = res;
    bus.start    = 1'b1;
    for (int c = 0; c <= end_edge; c++) begin
      if (c > 0) begin
        bus.start       = disturb && (c == 10);
        bus.wrEn        = disturb && (c == 10);
        bus.wrAddr      = 6'd5;
        bus.wrData      = 16'h7FFF;
        bus.outputValid = (ov_n > 0 && c >= NPIX + 1 + ov_n) || (stale_ov && c >= 20 && c < 24);
      end
      tick();
      if (c == 0) chk("timeout_cleared_on_start", bus.timeout, 1'b0);
      if (bus.convReset) begin
        conv_n++;
        if (conv_edge < 0) conv_edge = c;
      end
      if (bus.pixelValid) begin
        got_q.push_back(bus.inputPixel);
        if (first_pv < 0) first_pv = c;
        last_pv = c;
      end
      if (bus.resultValid) rv_n++;
      if (c < end_edge && !bus.busy) busy_ok = 1'b0;
    end
    chk("convreset_count", conv_n, 1);
    chk("convreset_cycle", conv_edge, 0);
    chk("pixel_count", got_q.size(), NPIX);
    chk("first_pixel_cycle", first_pv, 1);
    chk("last_pixel_cycle", last_pv, NPIX);
    for (int i = 0; i < got_q.size() && i < NPIX; i++)
      chk($sformatf("pixel[%0d]", i), got_q[i], m_buf[i]);
    chk("busy_through_frame", busy_ok, 1'b1);
    chk("busy_at_end", bus.busy, 1'b0);
    if (ov_n > 0) begin
      m_result  = res;
      m_timeout = 1'b0;
    end else begin
      m_timeout = 1'b1;
    end
    chk("resultvalid_count", rv_n, (ov_n > 0) ? 1 : 0);
    chk("resultvalid_at_end", bus.resultValid, ov_n > 0);
    chk("result", bus.result, m_result);
    chk("timeout", bus.timeout, m_timeout);
    bus.wrEn  = 1'b0;
    bus.start = chain_start;
  endtask

  task automatic idle_check(input int n, input bit ov);
    for (int i = 0; i < n; i++) begin
      bus.outputValid = ov;
      bus.start       = 1'b0;
      tick();
      chk("idle_busy", bus.busy, 1'b0);
      chk("idle_resultvalid", bus.resultValid, 1'b0);
      chk("idle_convreset", bus.convReset, 1'b0);
    end
    bus.outputValid = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_busy"}, bus.busy, 1'b0);
    chk({tag, "_convreset"}, bus.convReset, 1'b0);
    chk({tag, "_pixelvalid"}, bus.pixelValid, 1'b0);
    chk({tag, "_inputpixel"}, bus.inputPixel, '0);
    chk({tag, "_resultvalid"}, bus.resultValid, 1'b0);
    chk({tag, "_timeout"}, bus.timeout, 1'b0);
    chk({tag, "_result"}, bus.result, '0);
  endtask

  task automatic reset_mid_frame();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (31) tick();
    chk("pre_reset_pixelvalid", bus.pixelValid, 1'b1);
    chk("pre_reset_pixel30", bus.inputPixel, m_buf[30]);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_result  = '0;
    m_timeout = 1'b0;
    check_reset_values("midreset");
  endtask

  initial begin
    bit chain;
    bus.wrEn        = 1'b0;
    bus.wrAddr      = '0;
    bus.wrData      = '0;
    bus.start       = 1'b0;
    bus.outputValid = 1'b0;
    bus.resultIn    = '0;
    m_result        = '0;
    m_timeout       = 1'b0;
    repeat (3) tick();
    check_reset_values("reset");
    rst = 1'b0;
    tick();

    for (int i = 0; i < NPIX; i++) write_buf(i, BW'(i));

    begin
      logic [RW-1:0] res_a;
      for (int j = 0; j < OSZ; j++) res_a[j*BW +: BW] = BW'(100 + j);
      run_frame(10, 1'b0, 1'b0, res_a, 1'b0);
    end
    idle_check(3, 1'b0);

    run_frame(0, 1'b0, 1'b0, rand_vec(), 1'b0);
    idle_check(2, 1'b0);

    run_frame(12, 1'b1, 1'b1, rand_vec(), 1'b0);
    idle_check(3, 1'b0);

    run_frame(1, 1'b0, 1'b1, rand_vec(), 1'b0);
    idle_check(4, 1'b1);

    reset_mid_frame();
    tick();
    run_frame(5, 1'b0, 1'b0, rand_vec(), 1'b0);
    idle_check(2, 1'b0);

    for (int i = 0; i < NPIX; i++) write_buf(i, 16'hFFC0);
    run_frame(7, 1'b0, 1'b0, rand_vec(), 1'b1);
    run_frame(3, 1'b0, 1'b0, rand_vec(), 1'b0);
    idle_check(2, 1'b0);

    chain = 1'b0;
    for (int f = 0; f < 6; f++) begin
      if (!chain) begin
        int nw;
        nw = $urandom_range(1, 12);
        for (int w = 0; w < nw; w++) write_buf($urandom_range(0, NPIX - 1), BW'($urandom));
      end
      if ($urandom_range(0, 1) == 1) begin
        int a;
        logic [BW-1:0] d;
        a = $urandom_range(0, NPIX - 1);
        d = BW'($urandom);
        bus.wrEn   = 1'b1;
        bus.wrAddr = 6'(a);
        bus.wrData = d;
        m_buf[a]   = d;
      end
      chain = ($urandom_range(0, 2) == 0);
      run_frame($urandom_range(1, 40), 1'b0, $urandom_range(0, 1) == 1, rand_vec(), chain);
    end
    if (chain) idle_check(1, 1'b0);
    idle_check(2, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/conv_frame_streamer.md
Name: conv_frame_streamer

Overview:
- Transmit side of the pixel-stream interface into the 2D convolution engine (conv2d_connector).
- Holds one square frame in a local buffer loaded by the host.
- On start: pulses the engine reset, streams every pixel one per clock, then waits for the engine's outputValid and captures the output vector.
- Replaces the hand-written stimulus sequence with synthesizable control, so frames can be issued back-to-back without manual resets.

Parameters:
- bitWidth, 16, width of pixel and result words (signed)
- imgDim, 8, frame side length; numPixels = imgDim*imgDim (64)
- outputSize, 16, number of result words captured from the engine
- timeoutCycles, 1023, maximum WAIT cycles before the frame is abandoned

Ports:
- clk_p  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- wrEn  in  1  frame buffer write strobe
- wrAddr  in  $clog2(numPixels)  buffer address; 0 = first pixel streamed
- wrData  in  bitWidth  signed pixel to store
- start  in  1  request one frame transfer
- busy  out  1  high in any state other than IDLE
- convReset  out  1  one-cycle reset pulse to the engine at frame start
- inputPixel  out  bitWidth  signed pixel to the engine
- pixelValid  out  1  high while inputPixel carries a frame pixel
- outputValid  in  1  engine result-ready flag
- resultIn  in  outputSize x bitWidth  engine output vector
- result  out  outputSize x bitWidth  captured result vector
- resultValid  out  1  one-cycle pulse when result updates
- timeout  out  1  sticky error flag: WAIT expired without outputValid

Behaviour:
- Reset values:
  - busy, convReset, pixelValid, resultValid and timeout = 0.
  - inputPixel = 0 and result = all zeros.
  - FSM = IDLE, counters = 0.
  - Buffer contents are not cleared and survive reset.
- All outputs are registered.
- FSM states: IDLE, PRIME, STREAM, WAIT.
- IDLE:
  - wrEn writes wrData to buf[wrAddr] at the clock edge.
  - start=1 clears timeout and moves to PRIME.
- PRIME (1 cycle): convReset=1, inputPixel=0, pixelValid=0.
- STREAM (numPixels cycles):
  - convReset=0, pixelValid=1, inputPixel = buf[k] for k = 0..numPixels-1.
  - After k = numPixels-1, go to WAIT.
- WAIT:
  - pixelValid=0, inputPixel=0; a cycle counter increments each cycle.
  - When outputValid=1: result <= resultIn, resultValid pulses 1 cycle, go to IDLE.
  - If the counter reaches timeoutCycles with no outputValid: timeout <= 1, go to IDLE; result is unchanged.
- Timing, with start sampled at edge 0:
  - convReset high cycle 1.
  - Pixels in cycles 2..numPixels+1 (2..65).
  - WAIT from cycle numPixels+2.
  - Earliest resultValid is the cycle after outputValid is first seen in WAIT.
- Boundary conditions:
  - start while busy: ignored, no queueing.
  - wrEn while busy: ignored, so the buffer is stable during a frame.
  - start and wrEn in the same IDLE cycle: the write commits and that pixel is streamed in this frame.
  - outputValid in IDLE, PRIME or STREAM: ignored, treated as stale from the previous frame.
  - outputValid held high across WAIT: captured once on the first WAIT cycle only.
  - outputValid on the same cycle the counter reaches timeoutCycles: capture wins, timeout stays 0.
  - reset mid-frame: next cycle FSM=IDLE and all outputs at reset values; the engine is not reset by this block until the next PRIME.
  - Back-to-back frames: start may be asserted in the same cycle resultValid pulses (FSM already IDLE), giving PRIME next cycle.
- Arithmetic: pixels and results are passed unmodified, with no sign extension or truncation. Counters are sized $clog2(numPixels) and $clog2(timeoutCycles+1) bits.

Test Plan:
- Load buf[i]=i (i=0..63), pulse start:
  - convReset=1 in exactly one cycle.
  - pixelValid=1 for exactly 64 consecutive cycles with inputPixel = 0,1,...,63.
  - busy stays high until the result is captured.
- Stub engine asserts outputValid 10 cycles into WAIT with resultIn[j]=16'sd100+j:
  - result matches resultIn.
  - resultValid is a single pulse.
  - busy drops in the same cycle.
- No outputValid:
  - timeout=1 after 1023 WAIT cycles, result is unchanged, busy=0.
  - Next start clears timeout.
- Robustness while busy:
  - Write buf[5]=16'h7FFF mid-stream and pulse start again mid-stream; both are ignored.
  - Streamed pixel 5 stays 5; only one frame occurs.
  - Assert outputValid during STREAM; no capture.
- Assert reset at pixel 30:
  - Next cycle pixelValid=0, inputPixel=0, busy=0.
  - Buffer is retained: a new start streams the same 0..63 sequence.
- Fill the buffer with 16'hFFC0 (negative), start, capture, then assert start in the resultValid cycle:
  - Second frame's convReset is on the next cycle.
  - Pixels arrive as 16'hFFC0 with no sign corruption.
